ex_alu_stage: RTL and testbench

//  EX-stage execute unit: consumes the 4-bit ALU operation code produced by the ALU controller plus operands,

---
 rtl/ex_alu_stage_pkg.sv | 25 ++
 rtl/ex_alu_stage_alu_core.sv | 51 +++++
 rtl/ex_alu_stage.sv | 148 ++++++++++++++
 tb/tb_ex_alu_stage.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/ex_alu_stage_pkg.sv
// Shared ALU operation codes and default datapath sizes for the EX stage.
package ex_alu_stage_pkg;

    localparam int unsigned WIDTH   = 32;
    localparam int unsigned SHAMT_W = 5;
    localparam int unsigned ALUOP_W = 4;
    localparam int unsigned REG_W   = 5;

    typedef enum logic [ALUOP_W-1:0] {
        ALU_ADDU = 4'h0,
        ALU_SUBU = 4'h1,
        ALU_AND  = 4'h2,
        ALU_OR   = 4'h3,
        ALU_XOR  = 4'h4,
        ALU_NOR  = 4'h5,
        ALU_SLT  = 4'h6,
        ALU_SLTU = 4'h7,
        ALU_LUI  = 4'h8,
        ALU_SLL  = 4'h9,
        ALU_SRL  = 4'hA,
        ALU_SRA  = 4'hB,
        ALU_XXX  = 4'hF
    } alu_op_e;

endpackage

// File: rtl/ex_alu_stage_alu_core.sv
// Combinational ALU: decodes the ALU_* code and computes the result; unknown codes flag illegal.
module alu_core
    import ex_alu_stage_pkg::*;
#(
    parameter int unsigned WIDTH   = ex_alu_stage_pkg::WIDTH,
    parameter int unsigned SHAMT_W = ex_alu_stage_pkg::SHAMT_W,
    parameter int unsigned ALUOP_W = ex_alu_stage_pkg::ALUOP_W
) (
    input  logic [ALUOP_W-1:0] alu_op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [SHAMT_W-1:0] shamt,
    output logic [WIDTH-1:0]   result,
    output logic               illegal
);

    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic             lt_signed;
    logic             lt_unsigned;

    assign sum         = a + b;
    assign diff        = a - b;
    assign lt_signed   = $signed(a) < $signed(b);
    assign lt_unsigned = a < b;

    always_comb begin
        result  = '0;
        illegal = 1'b0;
        case (alu_op_e'(alu_op))
            ALU_ADDU: result = sum;
            ALU_SUBU: result = diff;
            ALU_AND:  result = a & b;
            ALU_OR:   result = a | b;
            ALU_XOR:  result = a ^ b;
            ALU_NOR:  result = ~(a | b);
            ALU_SLT:  result = {{(WIDTH-1){1'b0}}, lt_signed};
            ALU_SLTU: result = {{(WIDTH-1){1'b0}}, lt_unsigned};
            ALU_LUI:  result = {b[15:0], 16'h0000};
            ALU_SLL:  result = b << shamt;
            ALU_SRL:  result = b >> shamt;
            ALU_SRA:  result = $signed(b) >>> shamt;
            default: begin
                // ALU_XXX and unassigned codes still flow so the pipeline stays in order.
                result  = '0;
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/ex_alu_stage.sv
// EX-stage execute unit: ALU on the input side feeding a main register plus one skid entry,
// so MEM back-pressure never reaches ID combinationally.
module ex_alu_stage
    import ex_alu_stage_pkg::*;
#(
    parameter int unsigned WIDTH   = ex_alu_stage_pkg::WIDTH,
    parameter int unsigned SHAMT_W = ex_alu_stage_pkg::SHAMT_W,
    parameter int unsigned ALUOP_W = ex_alu_stage_pkg::ALUOP_W,
    parameter int unsigned REG_W   = ex_alu_stage_pkg::REG_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [ALUOP_W-1:0] alu_op,
    input  logic [WIDTH-1:0]   op_a,
    input  logic [WIDTH-1:0]   op_b,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic [REG_W-1:0]   dest_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_result,
    output logic [REG_W-1:0]   out_dest,
    output logic               out_zero,
    output logic               out_illegal
);

    logic [WIDTH-1:0] alu_result;
    logic             alu_illegal;

    alu_core #(
        .WIDTH   (WIDTH),
        .SHAMT_W (SHAMT_W),
        .ALUOP_W (ALUOP_W)
    ) u_alu_core (
        .alu_op  (alu_op),
        .a       (op_a),
        .b       (op_b),
        .shamt   (shamt),
        .result  (alu_result),
        .illegal (alu_illegal)
    );

    logic             main_valid_q, main_valid_d;
    logic [WIDTH-1:0] main_result_q, main_result_d;
    logic [REG_W-1:0] main_dest_q, main_dest_d;
    logic             main_zero_q, main_zero_d;
    logic             main_illegal_q, main_illegal_d;

    logic             skid_valid_q, skid_valid_d;
    logic [WIDTH-1:0] skid_result_q, skid_result_d;
    logic [REG_W-1:0] skid_dest_q, skid_dest_d;
    logic             skid_zero_q, skid_zero_d;
    logic             skid_illegal_q, skid_illegal_d;

    logic accept;
    logic new_zero;

    // Ready depends only on registered state, never on out_ready.
    assign in_ready = rst_n & ~skid_valid_q;
    assign accept   = in_valid & in_ready;
    assign new_zero = (alu_result == '0);

    always_comb begin
        main_valid_d   = main_valid_q;
        main_result_d  = main_result_q;
        main_dest_d    = main_dest_q;
        main_zero_d    = main_zero_q;
        main_illegal_d = main_illegal_q;
        skid_valid_d   = skid_valid_q;
        skid_result_d  = skid_result_q;
        skid_dest_d    = skid_dest_q;
        skid_zero_d    = skid_zero_q;
        skid_illegal_d = skid_illegal_q;

        if (flush) begin
            main_valid_d   = 1'b0;
            main_result_d  = '0;
            main_dest_d    = '0;
            main_zero_d    = 1'b0;
            main_illegal_d = 1'b0;
            skid_valid_d   = 1'b0;
        end else if (skid_valid_q) begin
            // Skid full implies no accept this cycle; only a drain can move things.
            if (out_ready) begin
                main_valid_d   = 1'b1;
                main_result_d  = skid_result_q;
                main_dest_d    = skid_dest_q;
                main_zero_d    = skid_zero_q;
                main_illegal_d = skid_illegal_q;
                skid_valid_d   = 1'b0;
            end
        end else if (main_valid_q && !out_ready) begin
            if (accept) begin
                skid_valid_d   = 1'b1;
                skid_result_d  = alu_result;
                skid_dest_d    = dest_in;
                skid_zero_d    = new_zero;
                skid_illegal_d = alu_illegal;
            end
        end else begin
            // Main is empty or draining this edge: a new op goes straight to main.
            if (accept) begin
                main_valid_d   = 1'b1;
                main_result_d  = alu_result;
                main_dest_d    = dest_in;
                main_zero_d    = new_zero;
                main_illegal_d = alu_illegal;
            end else begin
                main_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            main_valid_q   <= 1'b0;
            main_result_q  <= '0;
            main_dest_q    <= '0;
            main_zero_q    <= 1'b0;
            main_illegal_q <= 1'b0;
            skid_valid_q   <= 1'b0;
            skid_result_q  <= '0;
            skid_dest_q    <= '0;
            skid_zero_q    <= 1'b0;
            skid_illegal_q <= 1'b0;
        end else begin
            main_valid_q   <= main_valid_d;
            main_result_q  <= main_result_d;
            main_dest_q    <= main_dest_d;
            main_zero_q    <= main_zero_d;
            main_illegal_q <= main_illegal_d;
            skid_valid_q   <= skid_valid_d;
            skid_result_q  <= skid_result_d;
            skid_dest_q    <= skid_dest_d;
            skid_zero_q    <= skid_zero_d;
            skid_illegal_q <= skid_illegal_d;
        end
    end

    assign out_valid   = main_valid_q;
    assign out_result  = main_result_q;
    assign out_dest    = main_dest_q;
    assign out_zero    = main_zero_q;
    assign out_illegal = main_illegal_q;

endmodule

// File: tb/tb_ex_alu_stage.sv
// Directed bench for ex_alu_stage: arithmetic vectors, skid back-pressure, flush and reset.
module tb_ex_alu_stage;
    import ex_alu_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  alu_op;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [4:0]  shamt;
    logic [4:0]  dest_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_dest;
    logic        out_zero;
    logic        out_illegal;

    int unsigned total  = 0;
    int unsigned passed = 0;
    int unsigned fails  = 0;

    always #5 clk = ~clk;

    ex_alu_stage dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .alu_op      (alu_op),
        .op_a        (op_a),
        .op_b        (op_b),
        .shamt       (shamt),
        .dest_in     (dest_in),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_dest    (out_dest),
        .out_zero    (out_zero),
        .out_illegal (out_illegal)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sh, input logic [4:0] d);
        alu_op   = op;
        op_a     = a;
        op_b     = b;
        shamt    = sh;
        dest_in  = d;
        in_valid = 1'b1;
    endtask

    // One op offered for exactly one edge.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sh, input logic [4:0] d);
        drive(op, a, b, sh, d);
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        alu_op = 4'h0; op_a = '0; op_b = '0; shamt = '0; dest_in = '0;
        step();
        step();
        chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_out_result", out_result, 32'd0);
        chk("rst_out_zero", {31'b0, out_zero}, 32'd0);
        chk("rst_out_illegal", {31'b0, out_illegal}, 32'd0);
        rst_n = 1'b1;
        step();
        chk("rel_in_ready", {31'b0, in_ready}, 32'd1);

        // Wrap-around add yields zero
        issue(ALU_ADDU, 32'hFFFF_FFFF, 32'h1, 5'd0, 5'd3);
        chk("addu_valid", {31'b0, out_valid}, 32'd1);
        chk("addu_result", out_result, 32'h0);
        chk("addu_zero", {31'b0, out_zero}, 32'd1);
        chk("addu_dest", {27'b0, out_dest}, 32'd3);

        issue(ALU_SLT, 32'hFFFF_FFFE, 32'h1, 5'd0, 5'd4);
        chk("slt_result", out_result, 32'h1);
        chk("slt_zero", {31'b0, out_zero}, 32'd0);
        issue(ALU_SLTU, 32'hFFFF_FFFE, 32'h1, 5'd0, 5'd4);
        chk("sltu_result", out_result, 32'h0);
        issue(ALU_SRA, 32'h0, 32'h8000_0000, 5'd4, 5'd5);
        chk("sra_result", out_result, 32'hF800_0000);
        issue(ALU_LUI, 32'h0, 32'h0000_1234, 5'd0, 5'd6);
        chk("lui_result", out_result, 32'h1234_0000);
        issue(ALU_SUBU, 32'd5, 32'd7, 5'd0, 5'd7);
        chk("subu_result", out_result, 32'hFFFF_FFFE);
        issue(ALU_SLL, 32'h0, 32'h1, 5'd31, 5'd8);
        chk("sll_result", out_result, 32'h8000_0000);
        issue(ALU_SRL, 32'h0, 32'h8000_0000, 5'd4, 5'd9);
        chk("srl_result", out_result, 32'h0800_0000);
        issue(ALU_NOR, 32'h0F0F_0000, 32'h0000_00F0, 5'd0, 5'd10);
        chk("nor_result", out_result, 32'hF0F0_FF0F);
        issue(ALU_XOR, 32'hFF00_FF00, 32'h0FF0_0FF0, 5'd0, 5'd11);
        chk("xor_result", out_result, 32'hF0F0_F0F0);
        step();
        chk("idle_valid", {31'b0, out_valid}, 32'd0);

        // Back-pressure: 1,2,3 streamed while MEM stalls
        out_ready = 1'b0;
        drive(ALU_ADDU, 32'd1, 32'd0, 5'd0, 5'd1);
        step();
        chk("bp1_in_ready", {31'b0, in_ready}, 32'd1);
        chk("bp1_out", out_result, 32'd1);
        drive(ALU_ADDU, 32'd2, 32'd0, 5'd0, 5'd2);
        step();
        chk("bp2_in_ready", {31'b0, in_ready}, 32'd0);
        chk("bp2_out", out_result, 32'd1);
        drive(ALU_ADDU, 32'd3, 32'd0, 5'd0, 5'd3);
        step();
        chk("bp3_in_ready", {31'b0, in_ready}, 32'd0);
        chk("bp3_out", out_result, 32'd1);
        out_ready = 1'b1;
        step();
        chk("bp4_out", out_result, 32'd2);
        chk("bp4_in_ready", {31'b0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
        chk("bp5_out", out_result, 32'd3);
        chk("bp5_valid", {31'b0, out_valid}, 32'd1);
        step();
        chk("bp6_valid", {31'b0, out_valid}, 32'd0);

        // Flush with main and skid full, op offered on the flush edge
        out_ready = 1'b0;
        issue(ALU_ADDU, 32'd10, 32'd0, 5'd0, 5'd1);
        issue(ALU_ADDU, 32'd20, 32'd0, 5'd0, 5'd2);
        chk("fl_full_ready", {31'b0, in_ready}, 32'd0);
        drive(ALU_ADDU, 32'd30, 32'd0, 5'd0, 5'd3);
        flush = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("fl_valid", {31'b0, out_valid}, 32'd0);
        chk("fl_in_ready", {31'b0, in_ready}, 32'd1);
        out_ready = 1'b1;
        step();
        chk("fl_after_valid", {31'b0, out_valid}, 32'd0);
        // Flush drops an op even when it was acceptable
        drive(ALU_ADDU, 32'd40, 32'd0, 5'd0, 5'd4);
        flush = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("fl_empty_valid", {31'b0, out_valid}, 32'd0);

        // Illegal codes still flow
        issue(ALU_XXX, 32'd9, 32'd9, 5'd0, 5'd12);
        chk("xxx_valid", {31'b0, out_valid}, 32'd1);
        chk("xxx_result", out_result, 32'd0);
        chk("xxx_illegal", {31'b0, out_illegal}, 32'd1);
        issue(ALU_ADDU, 32'd2, 32'd3, 5'd0, 5'd13);
        chk("after_xxx_result", out_result, 32'd5);
        chk("after_xxx_illegal", {31'b0, out_illegal}, 32'd0);
        issue(4'hC, 32'd2, 32'd3, 5'd0, 5'd14);
        chk("unk_illegal", {31'b0, out_illegal}, 32'd1);
        chk("unk_result", out_result, 32'd0);

        // Reset with both buffers full
        out_ready = 1'b0;
        issue(ALU_ADDU, 32'd7, 32'd0, 5'd0, 5'd7);
        issue(ALU_ADDU, 32'd8, 32'd0, 5'd0, 5'd8);
        rst_n = 1'b0;
        chk("mrst_in_ready", {31'b0, in_ready}, 32'd0);
        step();
        chk("mrst_valid", {31'b0, out_valid}, 32'd0);
        chk("mrst_result", out_result, 32'd0);
        chk("mrst_dest", {27'b0, out_dest}, 32'd0);
        chk("mrst_zero", {31'b0, out_zero}, 32'd0);
        chk("mrst_illegal", {31'b0, out_illegal}, 32'd0);
        chk("mrst_in_ready2", {31'b0, in_ready}, 32'd0);
        rst_n = 1'b1;
        out_ready = 1'b1;
        step();
        chk("mrst_rel_ready", {31'b0, in_ready}, 32'd1);
        chk("mrst_rel_valid", {31'b0, out_valid}, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
